// File: rtl/convo_ctrl_3x3_pkg.sv
// Shared definitions for the 3x3 convolution controller.
// Holds the controller state encoding, the default core latency and the window geometry.
package convo_ctrl_3x3_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StRun,
      StFlush,
      StDone
   } conv_state_e;

   localparam int unsigned CoreLatDefault = 4;
   localparam int unsigned WinWords       = 9;
   localparam int unsigned PixW           = 32;

endpackage

// File: rtl/conv_line_buf.sv
// Single-row pixel line buffer: one write and one read per cycle at the same column address.
// Read is asynchronous and returns the word stored before this cycle's write, so the output
// is the pixel from the same column one row earlier.
//   clk_i    : clock
//   we_i     : write enable (accepted pixel)
//   addr_i   : column address
//   wdata_i  : pixel to store
//   rdata_o  : pixel previously stored at addr_i
module conv_line_buf
   import convo_ctrl_3x3_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [PixW-1:0] wdata_i,
   output logic [PixW-1:0] rdata_o
);

   logic [PixW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/convo_ctrl_3x3.sv
// Streaming controller for an external 3x3 floating-point convolution core.
// Accepts a raster pixel stream, builds 3x3 windows from two line buffers plus a shift window,
// feeds the core and returns its results with valid/ready backpressure.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   start_i                 : frame start pulse (only honoured in idle)
//   pix_valid_i/pix_data_i  : pixel stream in; pix_ready_o accepts it
//   win_data_o              : 9 window words to core, word 0 top-left, word 8 bottom-right
//   core_valid_o            : core valid-in and pipeline enable
//   core_data_i             : core result
//   res_valid_o/res_data_o  : result out; res_ready_i accepts it
//   busy_o, frame_done_o    : status
module convo_ctrl_3x3
   import convo_ctrl_3x3_pkg::*;
#(
   parameter int unsigned IMG_W    = 8,
   parameter int unsigned IMG_H    = 8,
   parameter int unsigned CORE_LAT = CoreLatDefault
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     pix_valid_i,
   input  logic [PixW-1:0]          pix_data_i,
   output logic                     pix_ready_o,
   output logic [WinWords*PixW-1:0] win_data_o,
   output logic                     core_valid_o,
   input  logic [PixW-1:0]          core_data_i,
   output logic                     res_valid_o,
   output logic [PixW-1:0]          res_data_o,
   input  logic                     res_ready_i,
   output logic                     busy_o,
   output logic                     frame_done_o
);

   localparam int unsigned ColW = $clog2(IMG_W);
   localparam int unsigned RowW = $clog2(IMG_H);

   conv_state_e         state_q, state_d;
   logic [ColW-1:0]     col_q, col_d;
   logic [RowW-1:0]     row_q, row_d;
   logic [CORE_LAT-1:0] tok_q, tok_d;
   logic [PixW-1:0]     win_q [WinWords];
   logic [PixW-1:0]     win_d [WinWords];
   logic [PixW-1:0]     lb0_rd, lb1_rd;
   logic                slot_free, pix_acc, issue, drain, col_last, row_last;

   // Result is whatever sits at the core output when the token reaches the last stage.
   assign res_valid_o = tok_q[CORE_LAT-1];
   assign res_data_o  = core_data_i;
   assign slot_free   = !res_valid_o || res_ready_i;

   assign pix_ready_o = (state_q == StFill) || ((state_q == StRun) && slot_free);
   assign pix_acc     = pix_valid_i && pix_ready_o;
   assign col_last    = (col_q == ColW'(IMG_W - 1));
   assign row_last    = (row_q == RowW'(IMG_H - 1));

   assign issue = pix_acc && (state_q == StRun) && (col_q >= ColW'(2)) && (row_q >= RowW'(2));
   // A waiting result must be popped from the core even without a new window, otherwise an
   // accepted result would be presented twice.
   assign drain = res_valid_o || ((state_q == StFlush) && (tok_q != '0));

   assign core_valid_o = (issue || drain) && slot_free;
   assign tok_d        = core_valid_o ? ((tok_q << 1) | CORE_LAT'(issue)) : tok_q;

   // Row r-1 lives in lb0, row r-2 in lb1; lb1 is refilled from lb0's old word.
   conv_line_buf #(
      .DEPTH (IMG_W)
   ) u_lb_row1 (
      .clk_i   (clk_i),
      .we_i    (pix_acc),
      .addr_i  (col_q),
      .wdata_i (pix_data_i),
      .rdata_o (lb0_rd)
   );

   conv_line_buf #(
      .DEPTH (IMG_W)
   ) u_lb_row2 (
      .clk_i   (clk_i),
      .we_i    (pix_acc),
      .addr_i  (col_q),
      .wdata_i (lb0_rd),
      .rdata_o (lb1_rd)
   );

   // Window presented to the core already includes the pixel being accepted this cycle.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_d[3*r]   = win_q[3*r+1];
         win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = pix_data_i;
      for (int i = 0; i < WinWords; i++) begin
         win_data_o[PixW*i +: PixW] = win_d[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (pix_acc) begin
         win_q <= win_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      busy_o       = (state_q != StIdle);
      frame_done_o = 1'b0;

      if (pix_acc) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
      end

      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StFill;
               col_d   = '0;
               row_d   = '0;
            end
         end
         StFill: begin
            // Next pixel completes the first window; it is accepted in RUN so it issues.
            if (pix_acc && (row_d == RowW'(2)) && (col_d == ColW'(2))) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (pix_acc && col_last && row_last) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (tok_d == '0) begin
               state_d = StDone;
            end
         end
         StDone: begin
            frame_done_o = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         col_q   <= '0;
         row_q   <= '0;
         tok_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         tok_q   <= tok_d;
      end
   end

endmodule
